// File: rtl/dac_trigger_scheduler_pkg.sv
// Shared definitions for the DAC trigger scheduler: gpio_ctrl bit map,
// config register width, FSM states and the sampled control-bit bundle.
package dac_trigger_scheduler_pkg;

  localparam int unsigned config_reg_width = 16;
  localparam int unsigned gpio_w           = 16;

  // gpio_ctrl bit indices
  localparam int unsigned sdata            = 0;
  localparam int unsigned sched_offset_clk = 1;
  localparam int unsigned sched_period_clk = 2;
  localparam int unsigned sched_shots_clk  = 3;
  localparam int unsigned sched_start      = 4;
  localparam int unsigned sched_abort      = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // Control bits sampled every cycle for edge detection
  typedef struct packed {
    logic abort;
    logic start;
    logic shots_clk;
    logic period_clk;
    logic offset_clk;
  } sched_ctrl_t;

endpackage

// File: rtl/dac_trigger_scheduler_if.sv
// PS-side control bus and per-channel trigger/status signals of the scheduler.
interface dac_trigger_scheduler_if
  import dac_trigger_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = config_reg_width
) ();

  logic [gpio_w-1:0] gpio_ctrl;
  logic              select_in;
  logic [NUM_CH-1:0] ch_busy;
  logic [NUM_CH-1:0] trigger_out;
  logic              running;
  logic [CNT_W-1:0]  shot_index;
  logic              done;
  logic              overrun;

  modport master (
    output gpio_ctrl, select_in, ch_busy,
    input  trigger_out, running, shot_index, done, overrun
  );

  modport slave (
    input  gpio_ctrl, select_in, ch_busy,
    output trigger_out, running, shot_index, done, overrun
  );

endinterface

// File: rtl/dac_trigger_scheduler_shift.sv
// MSB-first serial configuration register; one bit enters the LSB per enable.
module dac_trigger_scheduler_shift #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         shift_en,
  input  logic         sdata,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[W-2:0], sdata};
    end
  end

endmodule

// File: rtl/dac_trigger_scheduler.sv
// Multi-channel trigger sequencer: fires each channel at its programmed offset
// within a period, repeats for a number of shots, and flags busy re-triggers.
module dac_trigger_scheduler
  import dac_trigger_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned CNT_W  = config_reg_width
) (
  input logic                    clk,
  input logic                    rst,
  dac_trigger_scheduler_if.slave bus
);

  localparam int unsigned OFF_W = NUM_CH * CNT_W;

  sched_state_e      state_q, state_d;
  sched_ctrl_t       ctrl_c, ctrl_q;
  logic [OFF_W-1:0]  offsets_cfg, offsets_w;
  logic [CNT_W-1:0]  period_cfg, shots_cfg, period_w;
  logic [CNT_W-1:0]  timer_q, timer_d, shots_left_q, shots_left_d;
  logic [CNT_W-1:0]  shot_index_q, shot_index_d;
  logic [NUM_CH-1:0] fired_q, fired_d, trigger_q, trigger_d, fire_c;
  logic              running_q, running_d, done_q, done_d, overrun_q, overrun_d;
  logic              snap_c, start_c, abort_c, sdata_c;
  logic              off_en_c, per_en_c, shots_en_c, unused_gpio_c;

  assign ctrl_c = sched_ctrl_t'{
    abort:      bus.gpio_ctrl[sched_abort],
    start:      bus.gpio_ctrl[sched_start],
    shots_clk:  bus.gpio_ctrl[sched_shots_clk],
    period_clk: bus.gpio_ctrl[sched_period_clk],
    offset_clk: bus.gpio_ctrl[sched_offset_clk]
  };
  assign sdata_c       = bus.gpio_ctrl[sdata];
  assign unused_gpio_c = ^bus.gpio_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctrl_q <= '0;
    else      ctrl_q <= ctrl_c;
  end

  assign start_c    = ctrl_c.start & ~ctrl_q.start;
  assign abort_c    = ctrl_c.abort;
  assign off_en_c   = bus.select_in & ctrl_c.offset_clk & ~ctrl_q.offset_clk;
  assign per_en_c   = bus.select_in & ctrl_c.period_clk & ~ctrl_q.period_clk;
  assign shots_en_c = bus.select_in & ctrl_c.shots_clk  & ~ctrl_q.shots_clk;

  dac_trigger_scheduler_shift #(.W(OFF_W)) u_offsets (
    .clk(clk), .rst_n(rst), .shift_en(off_en_c), .sdata(sdata_c), .q(offsets_cfg)
  );
  dac_trigger_scheduler_shift #(.W(CNT_W)) u_period (
    .clk(clk), .rst_n(rst), .shift_en(per_en_c), .sdata(sdata_c), .q(period_cfg)
  );
  dac_trigger_scheduler_shift #(.W(CNT_W)) u_shots (
    .clk(clk), .rst_n(rst), .shift_en(shots_en_c), .sdata(sdata_c), .q(shots_cfg)
  );

  // Working copy of the configuration, frozen for the duration of a run
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offsets_w <= '0;
      period_w  <= '0;
    end else if (snap_c) begin
      offsets_w <= offsets_cfg;
      period_w  <= (period_cfg == '0) ? CNT_W'(1) : period_cfg;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign fire_c[i] = (state_q == ST_RUN) && !fired_q[i] &&
                       (timer_q == offsets_w[i*CNT_W +: CNT_W]);
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    shots_left_d = shots_left_q;
    shot_index_d = shot_index_q;
    fired_d      = fired_q;
    trigger_d    = '0;
    running_d    = running_q;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    snap_c       = 1'b0;

    if (abort_c) begin
      state_d   = ST_IDLE;
      running_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c && (shots_cfg != '0)) begin
            state_d      = ST_RUN;
            snap_c       = 1'b1;
            timer_d      = '0;
            shots_left_d = shots_cfg;
            shot_index_d = '0;
            fired_d      = '0;
            overrun_d    = 1'b0;
            running_d    = 1'b1;
          end
        end
        ST_RUN: begin
          trigger_d = fire_c;
          fired_d   = fired_q | fire_c;
          if ((fire_c & bus.ch_busy) != '0) overrun_d = 1'b1;
          // End of shot: finish the sequence or rewind for the next shot
          if (timer_q == period_w - CNT_W'(1)) begin
            if (shots_left_q == CNT_W'(1)) begin
              state_d   = ST_IDLE;
              done_d    = 1'b1;
              running_d = 1'b0;
            end else begin
              shots_left_d = shots_left_q - CNT_W'(1);
              shot_index_d = shot_index_q + CNT_W'(1);
              timer_d      = '0;
              fired_d      = '0;
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      shots_left_q <= '0;
      shot_index_q <= '0;
      fired_q      <= '0;
      trigger_q    <= '0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      shots_left_q <= shots_left_d;
      shot_index_q <= shot_index_d;
      fired_q      <= fired_d;
      trigger_q    <= trigger_d;
      running_q    <= running_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.trigger_out = trigger_q;
  assign bus.running     = running_q;
  assign bus.shot_index  = shot_index_q;
  assign bus.done        = done_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: doc/dac_trigger_scheduler.md
# dac_trigger_scheduler

Multi-channel trigger sequencer that drives the `trigger_in` inputs of up to `NUM_CH` DAC channel controllers. It issues per-channel trigger pulses at programmed cycle offsets, repeats the pattern for a programmed number of shots at a fixed period, and flags channels re-triggered while still playing. It is configured over the shared `gpio_ctrl` serial bus and sits between the PS GPIO block and the per-channel DAC controllers.

## Interface
- `NUM_CH`, default 8: number of DAC channels sequenced.
- `CNT_W`, default `config_reg_width`: width of the offset, period, shot and index counters.
- `clk`  in  1  250 MHz RFSoC fabric clock; the block's only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `gpio_ctrl`  in  16  PS control bus; bit indices come from `rfsoc_config`.
- `select_in`  in  1  high when the PS addresses this block; gates configuration shifting.
- `ch_busy`  in  `NUM_CH`  per-channel busy indication, driven from each channel's `loopback_valid`.
- `trigger_out`  out  `NUM_CH`  one-cycle trigger pulse per channel.
- `running`  out  1  high while a sequence is active.
- `shot_index`  out  `CNT_W`  zero-based index of the current shot.
- `done`  out  1  one-cycle pulse when a sequence completes normally.
- `overrun`  out  1  sticky flag; a trigger was issued while that channel's `ch_busy` was high.

## Operation
- **Configuration.** Three serial registers, each loaded MSB-first from `gpio_ctrl[sdata]` and only while `select_in` is high:
  - `offsets` (`NUM_CH*CNT_W` bits; channel i occupies slice i), shifted by `gpio_ctrl[sched_offset_clk]`.
  - `period`, shifted by `gpio_ctrl[sched_period_clk]`.
  - `shots`, shifted by `gpio_ctrl[sched_shots_clk]`.
- **Snapshot.** The configuration is copied into working registers at start. Shifting during a run has no effect on that run.
- **States:** `IDLE`, `RUN`.
- **IDLE to RUN.** Occurs on a sampled rising edge of `gpio_ctrl[sched_start]` (compared against the previous sampled value) when `shots != 0`. The same edge does all of the following:
  - snapshot the configuration
  - set `timer` to 0, `shots_left` to `shots`, and `shot_index` to 0
  - clear `fired` and `overrun`
  - set `running` to 1
- **Start with zero shots.** If `shots == 0`, the start edge is ignored and nothing is cleared.
- **Period of zero.** A snapshot `period` of 0 is treated as 1.
- **RUN, each cycle:**
  - For each channel i with `timer == offset[i]` and `!fired[i]`: register `trigger_out[i] <= 1` and set `fired[i]`.
  - If `ch_busy[i]` is high in that same cycle, also set `overrun`. The trigger is still issued.
  - Offsets `>= period` never fire.
- **End of a shot** (`timer == period-1`):
  - If `shots_left == 1`: go to `IDLE`, pulse `done`, clear `running`.
  - Otherwise: decrement `shots_left`, increment `shot_index`, set `timer` to 0, clear `fired`.
  - If neither applies, `timer` increments.
- **Abort.** `gpio_ctrl[sched_abort]` high (level) in any state forces `IDLE` on the next edge. It clears `running` and `trigger_out`, does not pulse `done`, and holds `overrun` and `shot_index`.
- **Simultaneous events:**
  - Abort wins over start and over a trigger in the same cycle.
  - A start edge while in `RUN` is ignored.
  - Several channels may trigger in the same cycle.

## Timing
- **Reset values.** All outputs are 0 on reset. Reset also zeroes all internal counters, the serial registers and the `fired` mask. Reset mid-run returns the block to `IDLE` immediately, with no `done` pulse.
- **Edge numbering.** E0 is the edge that samples the start rising edge.
- **Outputs after E0.** `running` is 1 after E0.
- **Trigger timing.** `trigger_out[i]` for shot s is high for exactly one cycle, after edge E(1 + s*P + offset[i]).
- **Shot index timing.** `shot_index` increments after edge E(s*P) for s ≥ 1.
- **Completion timing.** `done` is high, and `running` is low, after edge E(shots*P).
- **Earliest restart.** A new start edge is accepted from E(shots*P)+1 onward.
- **Counter widths.** `CNT_W` bits; no wrap is possible because `timer < period`.

## Structure
- **Package additions in `rfsoc_config`:**
  - `gpio_ctrl` bit indices `sched_offset_clk`, `sched_period_clk`, `sched_shots_clk`, `sched_start`, `sched_abort`.
  - `sdata` and `config_reg_width` are reused as they exist.
- **Sub-modules.** Reuse the existing `shift_register` for the three configuration registers. No new sub-module is required.
- **Per-channel logic.** Channel compare and fire logic is a generate loop over `NUM_CH`.

## Test plan
- **Basic sequence.** offsets {0,3,5,…}, P=10, shots=2, start → ch0 triggers after E1 and E11, ch1 after E4 and E14; `done` after E20; `shot_index` is 1 after E10.
- **Out-of-range offset and zero period.** offset[2]=12 with P=10 → ch2 never triggers. P=0, shots=3, offset 0 → ch0 triggers after E1, E2 and E3.
- **Overrun.** Hold `ch_busy[1]` high when ch1 fires → `overrun` is set and stays set until the next start. `trigger_out[1]` still pulses.
- **Abort.** Abort at E7 of a 3-shot run → `running` is 0 after E8, with no further triggers and no `done`. A start at E9 restarts cleanly with `shot_index` 0.
- **Ignored starts and config isolation.**
  - Start with shots=0 → nothing happens.
  - Second start edge during `RUN` → ignored.
  - Reshifting `period` mid-run → current timing unchanged.
- **Reset mid-run.** Assert `rst` low mid-run → all outputs are 0 immediately (asynchronously). After release, the block stays in `IDLE` until a start edge.
